// File: rtl/jtframe_sdram_resp_if.sv
`timescale 1ns/1ps
// Request/response bundle between a slot multiplexer (master) and the
// SDRAM responder (slave).
interface jtframe_sdram_resp_if #(
   parameter int SDRAMW = 22
);
   logic              sdram_rd;
   logic              sdram_wr;
   logic [SDRAMW-1:0] sdram_addr;
   logic [15:0]       data_write;
   logic [1:0]        sdram_wrmask;
   logic              sdram_ack;
   logic              data_rdy;
   logic [31:0]       data_read;
   logic              busy;

   modport master (
      output sdram_rd, sdram_wr, sdram_addr, data_write, sdram_wrmask,
      input  sdram_ack, data_rdy, data_read, busy
   );

   modport slave (
      input  sdram_rd, sdram_wr, sdram_addr, data_write, sdram_wrmask,
      output sdram_ack, data_rdy, data_read, busy
   );
endinterface

// File: rtl/jtframe_sdram_resp.sv
`timescale 1ns/1ps
// jtframe_sdram_resp: block-RAM stand-in for the SDRAM controller. Accepts
// one read/write at a time, acks it, and completes it after a fixed latency
// with a data_rdy pulse. Optional periodic refresh stalls are emulated.
module jtframe_sdram_resp #(
   parameter int SDRAMW  = 22,
   parameter int MEMAW   = 12,
   parameter int LATENCY = 4,
   parameter int WRLAT   = 2,
   parameter int REFRESH = 0,
   parameter int REFCYC  = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   jtframe_sdram_resp_if.slave bus
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;
   localparam logic [1:0] ST_REF  = 2'd3;

   localparam int MAXC0 = (LATENCY > WRLAT) ? LATENCY : WRLAT;
   localparam int MAXC  = (MAXC0 > REFCYC) ? MAXC0 : REFCYC;
   localparam int CW    = $clog2(MAXC + 1);

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [MEMAW-1:0] addr_q, addr_d, addr_nx;
   logic [15:0]      wdata_q, wdata_d;
   logic [1:0]       mask_q, mask_d;
   logic             ack_q, ack_d;
   logic             rdy_q, rdy_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             ref_pend_q, ref_pend_d;
   logic             ref_wrap;
   logic             mem_we;
   logic             accept;
   logic [15:0]      mem_q [0:(1<<MEMAW)-1];

   assign addr_nx = addr_q + MEMAW'(1);

   generate
      if (REFRESH > 0) begin : g_ref
         localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
         logic [RW-1:0] refcnt_q;
         assign ref_wrap = (refcnt_q == RW'(REFRESH - 1));
         // Free-running refresh period counter
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)        refcnt_q <= '0;
            else if (ref_wrap) refcnt_q <= '0;
            else               refcnt_q <= refcnt_q + RW'(1);
         end
      end else begin : g_noref
         assign ref_wrap = 1'b0;
      end
      if (SDRAMW > MEMAW) begin : g_alias
         logic unused_addr_hi;
         assign unused_addr_hi = ^bus.sdram_addr[SDRAMW-1:MEMAW];
      end
   endgenerate

   // Next-state logic: IDLE arbitration, latency counting, completion
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      mask_d     = mask_q;
      ack_d      = 1'b0;
      rdy_d      = 1'b0;
      rdata_d    = rdata_q;
      ref_pend_d = ref_pend_q;
      mem_we     = 1'b0;
      accept     = 1'b0;
      case (state_q)
         ST_IDLE: accept = 1'b1;
         ST_RD: begin
            if (cnt_q == CW'(1)) begin
               rdy_d   = 1'b1;
               rdata_d = {mem_q[addr_nx], mem_q[addr_q]};
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_WR: begin
            if (cnt_q == CW'(1)) begin
               rdy_d   = 1'b1;
               mem_we  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            // The last refresh edge arbitrates like IDLE, so a waiting
            // request is stalled by exactly REFCYC cycles.
            if (cnt_q == CW'(1)) begin
               state_d = ST_IDLE;
               accept  = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
      endcase
      if (accept) begin
         if (ref_pend_q) begin
            state_d    = ST_REF;
            cnt_d      = CW'(REFCYC);
            ref_pend_d = 1'b0;
         end else if (bus.sdram_rd || bus.sdram_wr) begin
            addr_d  = bus.sdram_addr[MEMAW-1:0];
            wdata_d = bus.data_write;
            mask_d  = bus.sdram_wrmask;
            ack_d   = 1'b1;
            state_d = bus.sdram_rd ? ST_RD : ST_WR;
            cnt_d   = bus.sdram_rd ? CW'(LATENCY) : CW'(WRLAT);
         end
      end
      if (ref_wrap) ref_pend_d = 1'b1;
   end

   // Control and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         mask_q     <= '0;
         ack_q      <= 1'b0;
         rdy_q      <= 1'b0;
         rdata_q    <= '0;
         ref_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         mask_q     <= mask_d;
         ack_q      <= ack_d;
         rdy_q      <= rdy_d;
         rdata_q    <= rdata_d;
         ref_pend_q <= ref_pend_d;
      end
   end

   // Byte-masked write commit at the write completion edge
   always_ff @(posedge clk) begin
      if (mem_we) begin
         if (!mask_q[0]) mem_q[addr_q][7:0]  <= wdata_q[7:0];
         if (!mask_q[1]) mem_q[addr_q][15:8] <= wdata_q[15:8];
      end
   end

   assign bus.sdram_ack = ack_q;
   assign bus.data_rdy  = rdy_q;
   assign bus.data_read = rdata_q;
   assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_jtframe_sdram_resp.sv
`timescale 1ns/1ps
// Scoreboard bench for jtframe_sdram_resp: one DUT without refresh for the
// data-path scenarios, a second with refresh enabled for the stall scenario.
module tb_jtframe_sdram_resp;
   localparam int SDRAMW = 22;
   localparam int MEMAW  = 12;
   localparam int LAT    = 4;
   localparam int WRL    = 2;
   localparam int REFP   = 64;
   localparam int REFC   = 6;

   logic clk = 1'b0;
   logic rst_n;
   logic rst_r_n;
   always #5 clk = ~clk;

   jtframe_sdram_resp_if #(.SDRAMW(SDRAMW)) bus_m ();
   jtframe_sdram_resp_if #(.SDRAMW(SDRAMW)) bus_r ();

   jtframe_sdram_resp #(
      .SDRAMW(SDRAMW), .MEMAW(MEMAW), .LATENCY(LAT), .WRLAT(WRL),
      .REFRESH(0), .REFCYC(REFC)
   ) u_main (.clk(clk), .rst_n(rst_n), .bus(bus_m.slave));

   jtframe_sdram_resp #(
      .SDRAMW(SDRAMW), .MEMAW(MEMAW), .LATENCY(LAT), .WRLAT(WRL),
      .REFRESH(REFP), .REFCYC(REFC)
   ) u_ref (.clk(clk), .rst_n(rst_r_n), .bus(bus_r.slave));

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb_q[$];
   logic [15:0] model [0:4095];
   logic [31:0] last_rd = '0;

   function automatic logic [31:0] exp_read(input logic [SDRAMW-1:0] addr);
      logic [11:0] a, a1;
      a  = addr[11:0];
      a1 = a + 12'd1;
      return {model[a1], model[a]};
   endfunction

   task automatic model_write(input logic [SDRAMW-1:0] addr, input logic [15:0] wd,
                              input logic [1:0] m);
      logic [11:0] a;
      a = addr[11:0];
      if (!m[0]) model[a][7:0]  = wd[7:0];
      if (!m[1]) model[a][15:8] = wd[15:8];
   endtask

   // Drives one request on the main DUT, drops it on ack, returns what was seen
   task automatic do_xact(input bit rd, input logic [SDRAMW-1:0] addr, input logic [15:0] wd,
                          input logic [1:0] m, output int ack_c, output int rdy_c,
                          output int n_acks, output logic [31:0] got, output logic [31:0] exp);
      sb_q.push_back(rd ? exp_read(addr) : last_rd);
      ack_c = -1; rdy_c = -1; n_acks = 0; got = '0;
      bus_m.sdram_rd = rd; bus_m.sdram_wr = !rd;
      bus_m.sdram_addr = addr; bus_m.data_write = wd; bus_m.sdram_wrmask = m;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(negedge clk);
         if (bus_m.sdram_ack) begin
            n_acks++;
            if (ack_c < 0) begin
               ack_c = cyc;
               bus_m.sdram_rd = 1'b0; bus_m.sdram_wr = 1'b0;
            end
         end
         if (bus_m.data_rdy) begin
            rdy_c = cyc;
            got   = bus_m.data_read;
            break;
         end
      end
      bus_m.sdram_rd = 1'b0; bus_m.sdram_wr = 1'b0;
      exp = sb_q.pop_front();
      if (rdy_c > 0) begin
         if (rd) last_rd = exp;
         else    model_write(addr, wd, m);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rst_r_n = 1'b0;
      #3;
      checks++; if (bus_m.sdram_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b expected 0", bus_m.sdram_ack); end
      checks++; if (bus_m.data_rdy !== 1'b0) begin errors++; $display("FAIL rst_rdy got %b expected 0", bus_m.data_rdy); end
      checks++; if (bus_m.data_read !== 32'h0) begin errors++; $display("FAIL rst_data got %h expected 0", bus_m.data_read); end
      checks++; if (bus_m.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b expected 0", bus_m.busy); end
      checks++; if (bus_r.busy !== 1'b0) begin errors++; $display("FAIL rst_ref_busy got %b expected 0", bus_r.busy); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_refresh();
      int ack_c, rdy_c, busy_low;
      rst_r_n = 1'b0;
      @(negedge clk);
      rst_r_n = 1'b1;
      repeat (REFP) @(negedge clk);
      checks++; if (bus_r.busy !== 1'b0) begin errors++; $display("FAIL ref_idle_at_wrap got %b expected 0", bus_r.busy); end
      bus_r.sdram_rd = 1'b1; bus_r.sdram_addr = 22'h040;
      ack_c = -1; rdy_c = -1; busy_low = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (ack_c < 0) begin
            if (!bus_r.busy) busy_low++;
            if (bus_r.sdram_ack) begin ack_c = cyc; bus_r.sdram_rd = 1'b0; end
         end else if (bus_r.data_rdy) begin
            rdy_c = cyc;
            break;
         end
      end
      bus_r.sdram_rd = 1'b0;
      checks++; if (ack_c !== 1 + REFC) begin errors++; $display("FAIL ref_ack_delay got %0d expected %0d", ack_c, 1 + REFC); end
      checks++; if (busy_low !== 0) begin errors++; $display("FAIL ref_busy_gap got %0d expected 0", busy_low); end
      checks++; if (rdy_c - ack_c !== LAT) begin errors++; $display("FAIL ref_rd_lat got %0d expected %0d", rdy_c - ack_c, LAT); end
   endtask

   task automatic test_read_latency();
      int ack_c, rdy_c, na;
      logic [31:0] got, exp;
      do_xact(1'b0, 22'h010, 16'h1234, 2'b00, ack_c, rdy_c, na, got, exp);
      checks++; if (rdy_c - ack_c !== WRL) begin errors++; $display("FAIL wr_lat got %0d expected %0d", rdy_c - ack_c, WRL); end
      do_xact(1'b0, 22'h011, 16'hABCD, 2'b00, ack_c, rdy_c, na, got, exp);
      do_xact(1'b1, 22'h010, 16'h0000, 2'b00, ack_c, rdy_c, na, got, exp);
      checks++; if (ack_c !== 1) begin errors++; $display("FAIL rd_ack_lat got %0d expected 1", ack_c); end
      checks++; if (rdy_c - ack_c !== LAT) begin errors++; $display("FAIL rd_lat got %0d expected %0d", rdy_c - ack_c, LAT); end
      checks++; if (na !== 1) begin errors++; $display("FAIL rd_ack_count got %0d expected 1", na); end
      checks++; if (got !== 32'hABCD1234) begin errors++; $display("FAIL rd_data got %h expected abcd1234", got); end
      @(negedge clk);
      checks++; if (bus_m.data_rdy !== 1'b0) begin errors++; $display("FAIL rdy_pulse got %b expected 0", bus_m.data_rdy); end
      checks++; if (bus_m.data_read !== exp) begin errors++; $display("FAIL rd_hold got %h expected %h", bus_m.data_read, exp); end
   endtask

   task automatic test_masked_write();
      int ack_c, rdy_c, na;
      logic [31:0] got, exp;
      do_xact(1'b0, 22'h020, 16'hFFFF, 2'b00, ack_c, rdy_c, na, got, exp);
      do_xact(1'b0, 22'h021, 16'h0F0F, 2'b00, ack_c, rdy_c, na, got, exp);
      do_xact(1'b0, 22'h020, 16'h5A5A, 2'b10, ack_c, rdy_c, na, got, exp);
      checks++; if (rdy_c - ack_c !== WRL) begin errors++; $display("FAIL mwr_lat got %0d expected %0d", rdy_c - ack_c, WRL); end
      checks++; if (got !== exp) begin errors++; $display("FAIL wr_keeps_read got %h expected %h", got, exp); end
      do_xact(1'b1, 22'h020, 16'h0000, 2'b00, ack_c, rdy_c, na, got, exp);
      checks++; if (got[15:0] !== 16'hFF5A) begin errors++; $display("FAIL mask_lo got %h expected ff5a", got[15:0]); end
      checks++; if (got !== exp) begin errors++; $display("FAIL mask_word got %h expected %h", got, exp); end
      do_xact(1'b0, 22'h020, 16'h0000, 2'b11, ack_c, rdy_c, na, got, exp);
      checks++; if (rdy_c - ack_c !== WRL) begin errors++; $display("FAIL noop_wr_lat got %0d expected %0d", rdy_c - ack_c, WRL); end
      do_xact(1'b1, 22'h020, 16'h0000, 2'b00, ack_c, rdy_c, na, got, exp);
      checks++; if (got !== 32'h0F0FFF5A) begin errors++; $display("FAIL noop_wr got %h expected 0f0fff5a", got); end
   endtask

   task automatic test_wrap_alias();
      int ack_c, rdy_c, na;
      logic [31:0] got, exp;
      do_xact(1'b0, 22'h3FFF, 16'h1111, 2'b00, ack_c, rdy_c, na, got, exp);
      do_xact(1'b0, 22'h1000, 16'h2222, 2'b00, ack_c, rdy_c, na, got, exp);
      do_xact(1'b1, 22'h1FFF, 16'h0000, 2'b00, ack_c, rdy_c, na, got, exp);
      checks++; if (got !== 32'h22221111) begin errors++; $display("FAIL wrap_alias got %h expected 22221111", got); end
   endtask

   // Presents transaction n of the two-slot multiplexer: even = read slot, odd = write slot
   task automatic present_slot(input int n);
      logic [SDRAMW-1:0] a;
      logic [15:0]       wd;
      bit                rd;
      rd = (n % 2 == 0);
      case ((n / 2) % 3)
         0:       a = 22'h010;
         1:       a = 22'h020;
         default: a = 22'h1FFF;
      endcase
      if (!rd) a = 22'h200 + SDRAMW'(n);
      wd = 16'hC000 + 16'(n);
      if (rd) begin
         last_rd = exp_read(a);
         sb_q.push_back(last_rd);
      end else begin
         sb_q.push_back(last_rd);
         model_write(a, wd, 2'b00);
      end
      bus_m.sdram_rd = rd; bus_m.sdram_wr = !rd;
      bus_m.sdram_addr = a; bus_m.data_write = wd; bus_m.sdram_wrmask = 2'b00;
   endtask

   task automatic test_back_to_back();
      int n_pres, n_ack, n_rdy, last_ack, last_n, outst;
      logic [31:0] e;
      n_pres = 0; n_ack = 0; n_rdy = 0; last_ack = -1; last_n = 0; outst = 0;
      present_slot(0);
      n_pres = 1;
      for (int cyc = 1; cyc <= 300 && n_rdy < 8; cyc++) begin
         @(negedge clk);
         if (bus_m.sdram_ack) begin
            checks++; if (outst !== 0) begin errors++; $display("FAIL b2b_ack_in_flight got %0d expected 0", outst); end
            if (last_ack >= 0) begin
               checks++;
               if (cyc - last_ack !== last_n + 1) begin errors++; $display("FAIL b2b_spacing got %0d expected %0d", cyc - last_ack, last_n + 1); end
            end
            last_ack = cyc;
            last_n   = bus_m.sdram_rd ? LAT : WRL;
            outst    = 1;
            n_ack++;
            if (n_pres < 8) begin
               present_slot(n_pres);
               n_pres++;
            end else begin
               bus_m.sdram_rd = 1'b0; bus_m.sdram_wr = 1'b0;
            end
         end
         if (bus_m.data_rdy) begin
            checks++; if (outst !== 1) begin errors++; $display("FAIL b2b_rdy_unpaired got %0d expected 1", outst); end
            outst = 0;
            n_rdy++;
            e = sb_q.pop_front();
            checks++; if (bus_m.data_read !== e) begin errors++; $display("FAIL b2b_data got %h expected %h", bus_m.data_read, e); end
         end
      end
      bus_m.sdram_rd = 1'b0; bus_m.sdram_wr = 1'b0;
      checks++; if (n_ack !== 8 || n_rdy !== 8) begin errors++; $display("FAIL b2b_count got %0d/%0d expected 8/8", n_ack, n_rdy); end
      sb_q.delete();
   endtask

   task automatic test_reset_mid_write();
      int ack_c, rdy_c, na, seen_rdy;
      logic [31:0] got, exp;
      do_xact(1'b0, 22'h030, 16'h7777, 2'b00, ack_c, rdy_c, na, got, exp);
      do_xact(1'b0, 22'h031, 16'h4444, 2'b00, ack_c, rdy_c, na, got, exp);
      bus_m.sdram_wr = 1'b1; bus_m.sdram_addr = 22'h030;
      bus_m.data_write = 16'h0000; bus_m.sdram_wrmask = 2'b00;
      ack_c = -1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         if (bus_m.sdram_ack) begin ack_c = cyc; break; end
      end
      bus_m.sdram_wr = 1'b0;
      checks++; if (ack_c < 0) begin errors++; $display("FAIL mid_wr_ack got %0d expected >0", ack_c); end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if ({bus_m.sdram_ack, bus_m.data_rdy, bus_m.busy} !== 3'b000) begin errors++; $display("FAIL mid_rst_ctrl got %b expected 000", {bus_m.sdram_ack, bus_m.data_rdy, bus_m.busy}); end
      checks++; if (bus_m.data_read !== 32'h0) begin errors++; $display("FAIL mid_rst_data got %h expected 0", bus_m.data_read); end
      seen_rdy = 0;
      repeat (2) begin
         @(negedge clk);
         if (bus_m.data_rdy) seen_rdy++;
      end
      rst_n = 1'b1;
      last_rd = '0;
      @(negedge clk);
      if (bus_m.data_rdy) seen_rdy++;
      checks++; if (seen_rdy !== 0) begin errors++; $display("FAIL mid_rst_rdy got %0d expected 0", seen_rdy); end
      do_xact(1'b1, 22'h030, 16'h0000, 2'b00, ack_c, rdy_c, na, got, exp);
      checks++; if (got !== 32'h44447777) begin errors++; $display("FAIL mid_rst_mem got %h expected 44447777", got); end
      checks++; if (ack_c !== 1) begin errors++; $display("FAIL post_rst_ack got %0d expected 1", ack_c); end
   endtask

   initial begin
      bus_m.sdram_rd = 1'b0; bus_m.sdram_wr = 1'b0; bus_m.sdram_addr = '0;
      bus_m.data_write = '0; bus_m.sdram_wrmask = 2'b11;
      bus_r.sdram_rd = 1'b0; bus_r.sdram_wr = 1'b0; bus_r.sdram_addr = '0;
      bus_r.data_write = '0; bus_r.sdram_wrmask = 2'b11;
      for (int i = 0; i < 4096; i++) model[i] = '0;
      test_reset();
      test_refresh();
      test_read_latency();
      test_masked_write();
      test_wrap_alias();
      test_back_to_back();
      test_reset_mid_write();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/jtframe_sdram_resp.md
# jtframe_sdram_resp

Responder-side model of the SDRAM controller handshake used by the slot multiplexers: it accepts `sdram_rd`/`sdram_wr` requests, acknowledges them, and completes each transaction with a `data_rdy` pulse. Reads return a 32-bit word pair. Storage is an internal block-RAM array, and SDRAM latency and refresh stalls are emulated. It sits in place of the real SDRAM controller, either on targets with enough BRAM or in fast simulation, directly under a slot multiplexer.

## Interface
Parameters:
- `SDRAMW`, 22: request address width, in 16-bit word units.
- `MEMAW`, 12: backing memory depth is 2^MEMAW 16-bit words.
- `LATENCY`, 4: read completion delay, in cycles from acceptance; minimum 2.
- `WRLAT`, 2: write completion delay, in cycles from acceptance; minimum 2.
- `REFRESH`, 0: refresh period in cycles; 0 disables refresh emulation.
- `REFCYC`, 6: number of stall cycles per refresh; minimum 1.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sdram_rd` in 1: read request, held high until `sdram_ack`.
- `sdram_wr` in 1: write request, held high until `sdram_ack`.
- `sdram_addr` in SDRAMW: word address.
- `data_write` in 16: write data.
- `sdram_wrmask` in 2: byte mask, active low; bit0 is `[7:0]`, bit1 is `[15:8]`.
- `sdram_ack` out 1: one-cycle pulse when a request is accepted.
- `data_rdy` out 1: one-cycle pulse when a transaction completes (reads and writes).
- `data_read` out 32: read data, valid from the `data_rdy` cycle and held until the next read completes.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States:
  - IDLE
  - RD: counting `LATENCY`.
  - WR: counting `WRLAT`.
  - REF: counting `REFCYC`.
- IDLE priority, highest first: refresh pending, then `sdram_rd`, then `sdram_wr`. If `sdram_rd` and `sdram_wr` are high together, the request is treated as a read.
- Acceptance, at the edge where IDLE samples a request:
  - latch `sdram_addr`, `data_write` and `sdram_wrmask`;
  - set `sdram_ack` for one cycle;
  - load the counter;
  - move to RD or WR.
- Outside IDLE, requests are not sampled. A request arriving during RD, WR or REF waits and is never acknowledged early.
- Memory index is `sdram_addr[MEMAW-1:0]`. Upper address bits are ignored, so addresses alias.
- Read result:
  - `data_read[15:0]` = mem[a];
  - `data_read[31:16]` = mem[(a+1) mod 2^MEMAW], so a read at the top word wraps to index 0.
- Write commit happens at the completion edge only. For each mask bit equal to 0, the matching byte of mem[a] takes `data_write`. Mask `2'b11` makes the write a no-op but it still completes normally. A write leaves `data_read` unchanged.
- Completion edge, for both RD and WR:
  - `data_rdy` = 1 for one cycle;
  - state returns to IDLE.
- Refresh emulation, only when `REFRESH` > 0:
  - a free-running counter wraps every `REFRESH` cycles; at each wrap it sets `ref_pending`;
  - `ref_pending` is serviced only from IDLE and never interrupts RD or WR;
  - entering REF clears `ref_pending`; REF lasts `REFCYC` cycles, then returns to IDLE;
  - if a wrap occurs while `ref_pending` is already set, the two refreshes merge into one.
- Memory contents are not affected by reset.

## Timing
- Reset values (asynchronous, while `rst_n` is low): `sdram_ack`=0, `data_rdy`=0, `data_read`=0, `busy`=0, state IDLE, all counters 0, `ref_pending`=0.
- Reset mid-transaction: the transaction is dropped, an uncommitted write is discarded, and no `data_rdy` is produced.
- Request sampled at edge E0:
  - `sdram_ack` is high during E0→E0+1;
  - `data_rdy` is high during (E0+N)→(E0+N+1), where N = `LATENCY` for reads and `WRLAT` for writes.
- Because `sdram_ack` is registered, a requester that clears its request on ack is never accepted twice.
- Earliest next acceptance is at E0+N+1, provided the request is already high then.
- Back-to-back throughput is one transaction per N+1 cycles.
- A refresh pending at the completion edge delays the next acceptance by `REFCYC` cycles.

## Test plan
- Read latency:
  - Stimulus: preload mem[0x010]=0x1234 and mem[0x011]=0xABCD; `LATENCY`=4; raise `sdram_rd` with addr 0x010 until ack.
  - Required: ack 1 cycle after sampling; `data_rdy` 4 cycles after sampling; `data_read`=0xABCD1234.
- Masked write:
  - Stimulus: mem[0x020]=0xFFFF; write 0x5A5A with mask 2'b10; then read 0x020.
  - Required: low half of the read data = 0xFF5A; `data_rdy` pulses `WRLAT` cycles after the write is accepted.
- Wrap and alias:
  - Stimulus: `MEMAW`=12; read address 0x1FFF.
  - Required: low half = mem[0xFFF], high half = mem[0x000].
- Refresh collision:
  - Stimulus: `REFRESH`=64, `REFCYC`=6; raise `sdram_rd` in the cycle the refresh wraps.
  - Required: ack delayed by exactly 6 cycles; `busy` high throughout.
- Back-to-back:
  - Stimulus: drive the block with a 2-slot multiplexer, both slots requesting continuously.
  - Required: transactions alternate; each `data_rdy` pairs with exactly one prior ack; no ack during RD/WR.
- Reset mid-write:
  - Stimulus: pull `rst_n` low one cycle after the write ack.
  - Required: outputs are 0 immediately; a later read shows the old memory contents.
